// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: owner codes, lock states
// and the idle byte-lane pattern.
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_NONE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_DMA  = 2'd2
    } arb_owner_e;

    typedef enum logic {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_e;

    localparam logic [3:0] BYTEEN_NONE = 4'b0000;

    // rr_last encoding: which requester won most recently
    localparam logic RR_CPU = 1'b0;
    localparam logic RR_DMA = 1'b1;

    function automatic logic [3:0] write_lanes(input logic we, input logic [3:0] byteen);
        return we ? byteen : BYTEEN_NONE;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// CPU, DMA and data-memory port signals shared between the arbiter (slave)
// and the requesters plus memory that surround it (master).
interface dm_arbiter_if;

    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_byteen;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;

    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [3:0]  dma_byteen;
    logic [31:0] dma_wdata;
    logic        dma_lock;
    logic        dma_gnt;
    logic        dma_ack;
    logic [31:0] dma_rdata;

    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_byteen, cpu_wdata,
        output cpu_stall, cpu_ack, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_byteen, dma_wdata, dma_lock,
        output dma_gnt, dma_ack, dma_rdata,
        output m_data_addr, m_data_wdata, m_data_byteen,
        input  m_data_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_byteen, cpu_wdata,
        input  cpu_stall, cpu_ack, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_byteen, dma_wdata, dma_lock,
        input  dma_gnt, dma_ack, dma_rdata,
        input  m_data_addr, m_data_wdata, m_data_byteen,
        output m_data_rdata
    );

endinterface

// File: rtl/dm_arb_lock_timer.sv
// DMA lock FSM with a saturating count of locked cycles; a release caused by
// the count running out (lock still held) gives the CPU the next cycle.
module dm_arb_lock_timer #(
    parameter int LOCK_MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic dma_gnt,
    input  logic dma_lock,
    output logic locked,
    output logic force_cpu
);
    import dm_arbiter_pkg::*;

    localparam int              CNT_W        = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(LOCK_MAX);
    localparam bit              LOCK_ALLOWED = (LOCK_MAX > 0);

    lock_state_e      state_q, state_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             force_cpu_q, force_cpu_d;

    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        force_cpu_d = 1'b0;
        cnt_inc     = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + CNT_W'(1);
        case (state_q)
            LOCK_UNLOCKED: begin
                lock_cnt_d = '0;
                if (LOCK_ALLOWED && dma_gnt && dma_lock) begin
                    state_d = LOCK_LOCKED;
                end
            end
            LOCK_LOCKED: begin
                lock_cnt_d = cnt_inc;
                if (!dma_lock || (cnt_inc == CNT_MAX)) begin
                    state_d     = LOCK_UNLOCKED;
                    lock_cnt_d  = '0;
                    force_cpu_d = dma_lock;
                end
            end
            default: begin
                state_d    = LOCK_UNLOCKED;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LOCK_UNLOCKED;
            lock_cnt_q  <= '0;
            force_cpu_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            force_cpu_q <= force_cpu_d;
        end
    end

    assign locked    = (state_q == LOCK_LOCKED);
    assign force_cpu = force_cpu_q;

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the data-memory port between CPU and DMA.
// Define DM_ARB_LOCK_EN to build the bounded DMA lock (dm_arb_lock_timer).
module dm_arbiter #(
    parameter int LOCK_MAX = 8
) (
    input  logic         clk,
    input  logic         reset,
    dm_arbiter_if.slave  bus
);
    import dm_arbiter_pkg::*;

    arb_owner_e  owner;
    logic        cpu_gnt;
    logic        dma_gnt;
    logic        locked;
    logic        force_cpu;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteen;

    logic        rr_last_q, rr_last_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        dma_ack_q, dma_ack_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;

`ifdef DM_ARB_LOCK_EN
    dm_arb_lock_timer #(
        .LOCK_MAX (LOCK_MAX)
    ) u_lock_timer (
        .clk       (clk),
        .reset     (reset),
        .dma_gnt   (dma_gnt),
        .dma_lock  (bus.dma_lock),
        .locked    (locked),
        .force_cpu (force_cpu)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^{bus.dma_lock, LOCK_MAX[0]};
    assign locked     = 1'b0;
    assign force_cpu  = 1'b0;
`endif

    // On a tie the requester that did not win last goes first, unless the
    // lock timer just forced a release in favour of the CPU.
    always_comb begin
        owner = ARB_NONE;
        if (locked) begin
            if (bus.dma_req) begin
                owner = ARB_DMA;
            end
        end else if (bus.cpu_req && bus.dma_req) begin
            owner = (force_cpu || (rr_last_q == RR_DMA)) ? ARB_CPU : ARB_DMA;
        end else if (bus.cpu_req) begin
            owner = ARB_CPU;
        end else if (bus.dma_req) begin
            owner = ARB_DMA;
        end
    end

    assign cpu_gnt = (owner == ARB_CPU);
    assign dma_gnt = (owner == ARB_DMA);

    always_comb begin
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_byteen = BYTEEN_NONE;
        case (owner)
            ARB_CPU: begin
                mem_addr   = bus.cpu_addr;
                mem_wdata  = bus.cpu_wdata;
                mem_byteen = write_lanes(bus.cpu_we, bus.cpu_byteen);
            end
            ARB_DMA: begin
                mem_addr   = bus.dma_addr;
                mem_wdata  = bus.dma_wdata;
                mem_byteen = write_lanes(bus.dma_we, bus.dma_byteen);
            end
            default: begin
                mem_addr   = '0;
                mem_wdata  = '0;
                mem_byteen = BYTEEN_NONE;
            end
        endcase
    end

    always_comb begin
        rr_last_d   = rr_last_q;
        cpu_ack_d   = cpu_gnt;
        dma_ack_d   = dma_gnt;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        if (cpu_gnt) begin
            rr_last_d = RR_CPU;
            if (!bus.cpu_we) begin
                cpu_rdata_d = bus.m_data_rdata;
            end
        end
        if (dma_gnt) begin
            rr_last_d = RR_DMA;
            if (!bus.dma_we) begin
                dma_rdata_d = bus.m_data_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last_q   <= RR_DMA;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            rr_last_q   <= rr_last_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign bus.cpu_stall     = bus.cpu_req & ~cpu_gnt;
    assign bus.cpu_ack       = cpu_ack_q;
    assign bus.cpu_rdata     = cpu_rdata_q;
    assign bus.dma_gnt       = dma_gnt;
    assign bus.dma_ack       = dma_ack_q;
    assign bus.dma_rdata     = dma_rdata_q;
    assign bus.m_data_addr   = mem_addr;
    assign bus.m_data_wdata  = mem_wdata;
    assign bus.m_data_byteen = mem_byteen;

endmodule
